// File: rtl/led_arbiter.sv
// led_arbiter: round-robin LED pattern arbiter with dwell time and urgent pre-emption
module led_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [23:0] DWELL        = 24'd8388608,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     urgent,
  input  logic [8*NUM_REQ-1:0]   pattern,
  output logic [7:0]             led,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);
  localparam int LW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [LW-1:0] LAST_MAX = LW'(NUM_REQ - 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_d;
  logic [LW-1:0] last, last_d, win, start;
  logic [23:0] cnt, cnt_d;
  logic [NUM_REQ-1:0] urg_req, cand, hot;
  logic found;
  int idx;
  assign urg_req = req & urgent;
  assign cand = |urg_req ? urg_req : req;
  assign start = last == LAST_MAX ? '0 : last + 1'b1;
  assign hot = NUM_REQ'(1) << last;
  // first candidate at or after start, wrapping by explicit compare
  always_comb begin
    found = 1'b0;
    win = start;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k >= NUM_REQ ? int'(start) + k - NUM_REQ : int'(start) + k;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = LW'(idx);
      end
    end
  end
  // next grant, dwell count and state; in HOLD, last is the granted index
  always_comb begin
    state_d = state;
    last_d = last;
    cnt_d = cnt == 24'd0 ? 24'd0 : cnt - 24'd1;
    if (state == IDLE) begin
      if (found) begin
        state_d = HOLD;
        last_d = win;
        cnt_d = DWELL - 24'd1;
      end
    end else if (!req[last]) begin
      state_d = found ? HOLD : IDLE;
      last_d = found ? win : last;
      cnt_d = found ? DWELL - 24'd1 : 24'd0;
    end else if ((!urgent[last] && |(urg_req & ~hot)) || (cnt == 24'd0 && |(cand & ~hot))) begin
      last_d = win;
      cnt_d = DWELL - 24'd1;
    end
  end
  // state and registered outputs all update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= LAST_MAX;
      cnt   <= 24'd0;
      grant <= '0;
      led   <= IDLE_PATTERN;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      last  <= last_d;
      cnt   <= cnt_d;
      grant <= state_d == HOLD ? NUM_REQ'(1) << last_d : '0;
      led   <= state_d == HOLD ? pattern[8*int'(last_d) +: 8] : IDLE_PATTERN;
      busy  <= state_d == HOLD;
    end
  end
endmodule
